hazard_ctrl_gen: RTL and testbench
==================================

HAZARD_CTRL_GEN -- requirements
Module: hazard_ctrl_gen

Interface
REQ-001 SHALL have parameter RA_W, default 5, meaning register-address width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, legal 1..2, meaning pipeline stages after EX before load data can be forwarded.
REQ-003 SHALL have parameter MDU_LAT, default 4, legal >=1, meaning total stall cycles per multi-cycle MDU operation.
REQ-004 SHALL have parameter CNT_W, default 16, meaning width of each saturating performance counter.
REQ-005 SHALL have port clk, input, 1, meaning the single clock.
REQ-006 SHALL have port rstn, input, 1, meaning reset, asynchronous and active-low.
REQ-007 SHALL have ports rf_we_ex, rf_we_mem, input, 1 each, meaning register-write enable of EX and MEM instructions.
REQ-008 SHALL have ports rf_wd_sel_ex, rf_wd_sel_mem, input, 2 each, meaning write-data source; 2'b01 = load.
REQ-009 SHALL have ports rf_wa_ex, rf_wa_mem, rf_ra0_id, rf_ra1_id, input, RA_W each, meaning destination and ID source addresses.
REQ-010 SHALL have port npc_sel, input, 2, meaning next-PC select from EX; 2'b01 or 2'b10 = taken redirect.
REQ-011 SHALL have port mdu_start_ex, input, 1, meaning EX holds a multi-cycle MDU instruction.
REQ-012 SHALL have port dmem_ready, input, 1, meaning data memory completes this cycle (0 = wait state).
REQ-013 SHALL have outputs stall_pc, stall_if2id, stall_id2ex, stall_ex2mem, stall_mem2wb, 1 each, meaning hold the named register.
REQ-014 SHALL have outputs flush_if2id, flush_id2ex, flush_ex2mem, 1 each, meaning load a bubble into the named register.
REQ-015 SHALL have output mdu_done, 1, meaning one-cycle pulse: MDU result valid, EX may advance.
REQ-016 SHALL have outputs cnt_load_use, cnt_mdu, cnt_flush, cnt_mem_wait, CNT_W each, meaning event counters.

Function
REQ-017 Load-use-EX hazard: rf_we_ex & rf_wd_sel_ex==01 & rf_wa_ex!=0 & rf_wa_ex matches either ID source.
REQ-018 Load-use-MEM hazard (LOAD_LAT==2 only; tied 0 otherwise): same test using the MEM-stage inputs.
REQ-019 Priority, highest first: memory wait, MDU stall, load-use-EX, redirect, load-use-MEM.
REQ-020 Memory wait (dmem_ready==0): all five stall outputs 1, all flushes 0, MDU FSM and counter frozen.
REQ-021 MDU FSM states IDLE, BUSY, DONE; IDLE->BUSY on mdu_start_ex (->DONE directly if MDU_LAT==1), loading rem=MDU_LAT-1.
REQ-022 Start cycle and every BUSY cycle: stall_pc, stall_if2id, stall_id2ex = 1; flush_ex2mem = 1; all other stall/flush outputs 0.
REQ-023 BUSY decrements rem each unfrozen cycle and moves to DONE when rem==1; total stall = MDU_LAT cycles.
REQ-024 DONE lasts one cycle: mdu_done=1, mdu_start_ex ignored, no MDU stall, next state IDLE.
REQ-025 Load-use-EX or load-use-MEM: stall_pc, stall_if2id = 1; flush_id2ex = 1; exactly one cycle per occurrence.
REQ-026 Redirect: flush_if2id = flush_id2ex = 1, no stalls; redirect overrides load-use-MEM.
REQ-027 Outputs not asserted by the winning condition SHALL be 0; all stall/flush outputs combinational from inputs and FSM state.
REQ-028 Counters increment by 1 on each cycle their condition wins (cnt_mdu: every MDU stall cycle), saturate at all-ones, never wrap.
REQ-029 rf address 0 SHALL never raise a hazard.

Reset
REQ-030 rstn low SHALL asynchronously force FSM to IDLE, rem to 0, all counters to 0, mdu_done to 0.
REQ-031 Reset during BUSY SHALL abandon the operation; first cycle after release the FSM is IDLE and start is sampled fresh.
REQ-032 During reset, stall/flush outputs reflect only combinational hazard terms with the FSM in IDLE.

Structure
REQ-033 npc_sel encodings, load wd_sel code 2'b01 and FSM state encoding SHALL reside in shared package pipe_pkg.
REQ-034 The MDU FSM with its counter SHALL be a sub-module mdu_stall_fsm; hazard decode and counters stay in the top.

Verification
REQ-035 rf_we_ex=1, wd_sel_ex=01, wa_ex=5, ra0_id=5 -> one cycle stall_pc=stall_if2id=flush_id2ex=1, cnt_load_use=1.
REQ-036 Same with wa_ex=0, ra0_id=0 -> all outputs 0.
REQ-037 MDU_LAT=4, mdu_start_ex held high -> 4 stall cycles with flush_ex2mem=1, then mdu_done=1 for 1 cycle, cnt_mdu=4.
REQ-038 dmem_ready=0 for 3 cycles mid-BUSY -> all stalls 1, rem frozen, MDU total still 4 stall cycles, cnt_mem_wait=3.
REQ-039 LOAD_LAT=2, MEM load wa=7, ra1_id=7, npc_sel=10 same cycle -> flush_if2id=flush_id2ex=1, no stall, cnt_flush=1.
REQ-040 CNT_W=2, five load-use events -> cnt_load_use stays 3; rstn pulse during BUSY -> next cycle no stall, counters 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: next-PC select codes, write-data source codes, MDU FSM states.
// Purely declarative, no logic of its own.
package pipe_pkg;

  localparam logic [1:0] NPC_BRANCH  = 2'b01;
  localparam logic [1:0] NPC_JUMP    = 2'b10;
  localparam logic [1:0] WD_SEL_LOAD = 2'b01;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_BUSY = 2'b01,
    MDU_DONE = 2'b10
  } mdu_state_e;

  function automatic logic is_redirect(input logic [1:0] npc_sel);
    return (npc_sel == NPC_BRANCH) || (npc_sel == NPC_JUMP);
  endfunction

endpackage

// File: rtl/mdu_stall_fsm.sv
// Multi-cycle MDU stall sequencer: stalls for MDU_LAT cycles from the start cycle, then pulses done.
// Latency: stall is combinational on start; freeze_i holds state and remaining count.
module mdu_stall_fsm
  import pipe_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic start_i,
  input  logic freeze_i,
  output logic stall_o,
  output logic done_o
);

  localparam int REM_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic [REM_W-1:0] REM_INIT = REM_W'(MDU_LAT - 1);

  mdu_state_e       state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= MDU_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (start_i) begin
          stall_o = 1'b1;
          rem_d   = REM_INIT;
          state_d = (MDU_LAT == 1) ? MDU_DONE : MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        stall_o = 1'b1;
        rem_d   = rem_q - 1'b1;
        if (rem_q == REM_W'(1)) state_d = MDU_DONE;
      end
      MDU_DONE: begin
        done_o  = 1'b1;
        state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
    // A memory wait holds the whole pipe, so the MDU neither advances nor reports done.
    if (freeze_i) begin
      state_d = state_q;
      rem_d   = rem_q;
      done_o  = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_ctrl_gen.sv
// Pipeline hazard controller: prioritised stall/flush decode plus saturating event counters.
// Stall/flush outputs are combinational; counters update one cycle after their event wins.
module hazard_ctrl_gen
  import pipe_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1,
  parameter int MDU_LAT  = 4,
  parameter int CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            rf_we_ex,
  input  logic            rf_we_mem,
  input  logic [1:0]      rf_wd_sel_ex,
  input  logic [1:0]      rf_wd_sel_mem,
  input  logic [RA_W-1:0] rf_wa_ex,
  input  logic [RA_W-1:0] rf_wa_mem,
  input  logic [RA_W-1:0] rf_ra0_id,
  input  logic [RA_W-1:0] rf_ra1_id,
  input  logic [1:0]      npc_sel,
  input  logic            mdu_start_ex,
  input  logic            dmem_ready,
  output logic            stall_pc,
  output logic            stall_if2id,
  output logic            stall_id2ex,
  output logic            stall_ex2mem,
  output logic            stall_mem2wb,
  output logic            flush_if2id,
  output logic            flush_id2ex,
  output logic            flush_ex2mem,
  output logic            mdu_done,
  output logic [CNT_W-1:0] cnt_load_use,
  output logic [CNT_W-1:0] cnt_mdu,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_mem_wait
);

  function automatic logic load_hit(input logic we, input logic [1:0] sel,
                                    input logic [RA_W-1:0] wa);
    return we && (sel == WD_SEL_LOAD) && (wa != '0) &&
           ((wa == rf_ra0_id) || (wa == rf_ra1_id));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + 1'b1 : v;
  endfunction

  logic mem_wait, mdu_stall, lu_ex, lu_mem, redirect;
  logic win_mem, win_mdu, win_lu, win_flush;
  logic [CNT_W-1:0] cnt_lu_q, cnt_lu_d, cnt_mdu_q, cnt_mdu_d;
  logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d, cnt_mw_q, cnt_mw_d;

  assign mem_wait = !dmem_ready;
  assign lu_ex    = load_hit(rf_we_ex, rf_wd_sel_ex, rf_wa_ex);
  assign lu_mem   = (LOAD_LAT == 2) ? load_hit(rf_we_mem, rf_wd_sel_mem, rf_wa_mem) : 1'b0;
  assign redirect = is_redirect(npc_sel);

  mdu_stall_fsm #(.MDU_LAT(MDU_LAT)) u_mdu (
    .clk      (clk),
    .rstn     (rstn),
    .start_i  (mdu_start_ex),
    .freeze_i (mem_wait),
    .stall_o  (mdu_stall),
    .done_o   (mdu_done)
  );

  always_comb begin
    {stall_pc, stall_if2id, stall_id2ex, stall_ex2mem, stall_mem2wb} = '0;
    {flush_if2id, flush_id2ex, flush_ex2mem} = '0;
    {win_mem, win_mdu, win_lu, win_flush} = '0;
    if (mem_wait) begin
      {stall_pc, stall_if2id, stall_id2ex, stall_ex2mem, stall_mem2wb} = '1;
      win_mem = 1'b1;
    end else if (mdu_stall) begin
      {stall_pc, stall_if2id, stall_id2ex} = '1;
      flush_ex2mem = 1'b1;
      win_mdu = 1'b1;
    end else if (lu_ex) begin
      {stall_pc, stall_if2id, flush_id2ex} = '1;
      win_lu = 1'b1;
    end else if (redirect) begin
      {flush_if2id, flush_id2ex} = '1;
      win_flush = 1'b1;
    end else if (lu_mem) begin
      {stall_pc, stall_if2id, flush_id2ex} = '1;
      win_lu = 1'b1;
    end
  end

  always_comb begin
    cnt_lu_d    = sat_inc(cnt_lu_q, win_lu);
    cnt_mdu_d   = sat_inc(cnt_mdu_q, win_mdu);
    cnt_flush_d = sat_inc(cnt_flush_q, win_flush);
    cnt_mw_d    = sat_inc(cnt_mw_q, win_mem);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_lu_q    <= '0;
      cnt_mdu_q   <= '0;
      cnt_flush_q <= '0;
      cnt_mw_q    <= '0;
    end else begin
      cnt_lu_q    <= cnt_lu_d;
      cnt_mdu_q   <= cnt_mdu_d;
      cnt_flush_q <= cnt_flush_d;
      cnt_mw_q    <= cnt_mw_d;
    end
  end

  assign cnt_load_use = cnt_lu_q;
  assign cnt_mdu      = cnt_mdu_q;
  assign cnt_flush    = cnt_flush_q;
  assign cnt_mem_wait = cnt_mw_q;

endmodule

// File: tb/tb_hazard_ctrl_gen.sv
// Bench for hazard_ctrl_gen: a default instance and a LOAD_LAT=2 / CNT_W=2 instance share stimulus.
// Expected outputs are queued per cycle and checked mid-cycle; counters track a bench-side tally.
module tb_hazard_ctrl_gen;
  localparam int RA_W = 5;
  localparam logic [8:0] O_NONE = 9'h000;
  localparam logic [8:0] O_MEMW = 9'h1F0;
  localparam logic [8:0] O_MDU  = 9'h1C2;
  localparam logic [8:0] O_LU   = 9'h184;
  localparam logic [8:0] O_RDR  = 9'h00C;
  localparam logic [8:0] O_DONE = 9'h001;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic            rf_we_ex, rf_we_mem, mdu_start_ex, dmem_ready;
  logic [1:0]      rf_wd_sel_ex, rf_wd_sel_mem, npc_sel;
  logic [RA_W-1:0] rf_wa_ex, rf_wa_mem, rf_ra0_id, rf_ra1_id;

  logic [8:0]  out_a, out_b;
  logic [15:0] cnt_a [4];
  logic [1:0]  cnt_b [4];

  hazard_ctrl_gen #(.RA_W(RA_W), .LOAD_LAT(1), .MDU_LAT(4), .CNT_W(16)) u_a (
    .clk(clk), .rstn(rstn),
    .rf_we_ex(rf_we_ex), .rf_we_mem(rf_we_mem),
    .rf_wd_sel_ex(rf_wd_sel_ex), .rf_wd_sel_mem(rf_wd_sel_mem),
    .rf_wa_ex(rf_wa_ex), .rf_wa_mem(rf_wa_mem), .rf_ra0_id(rf_ra0_id), .rf_ra1_id(rf_ra1_id),
    .npc_sel(npc_sel), .mdu_start_ex(mdu_start_ex), .dmem_ready(dmem_ready),
    .stall_pc(out_a[8]), .stall_if2id(out_a[7]), .stall_id2ex(out_a[6]),
    .stall_ex2mem(out_a[5]), .stall_mem2wb(out_a[4]),
    .flush_if2id(out_a[3]), .flush_id2ex(out_a[2]), .flush_ex2mem(out_a[1]),
    .mdu_done(out_a[0]),
    .cnt_load_use(cnt_a[0]), .cnt_mdu(cnt_a[1]), .cnt_flush(cnt_a[2]), .cnt_mem_wait(cnt_a[3])
  );

  hazard_ctrl_gen #(.RA_W(RA_W), .LOAD_LAT(2), .MDU_LAT(4), .CNT_W(2)) u_b (
    .clk(clk), .rstn(rstn),
    .rf_we_ex(rf_we_ex), .rf_we_mem(rf_we_mem),
    .rf_wd_sel_ex(rf_wd_sel_ex), .rf_wd_sel_mem(rf_wd_sel_mem),
    .rf_wa_ex(rf_wa_ex), .rf_wa_mem(rf_wa_mem), .rf_ra0_id(rf_ra0_id), .rf_ra1_id(rf_ra1_id),
    .npc_sel(npc_sel), .mdu_start_ex(mdu_start_ex), .dmem_ready(dmem_ready),
    .stall_pc(out_b[8]), .stall_if2id(out_b[7]), .stall_id2ex(out_b[6]),
    .stall_ex2mem(out_b[5]), .stall_mem2wb(out_b[4]),
    .flush_if2id(out_b[3]), .flush_id2ex(out_b[2]), .flush_ex2mem(out_b[1]),
    .mdu_done(out_b[0]),
    .cnt_load_use(cnt_b[0]), .cnt_mdu(cnt_b[1]), .cnt_flush(cnt_b[2]), .cnt_mem_wait(cnt_b[3])
  );

  typedef struct {
    logic [8:0] a;
    logic [8:0] b;
    string      tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned ta[4];
  int unsigned tbc[4];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int cls(input logic [8:0] v);
    // Winning condition implied by the expected output pattern (mdu_done ignored).
    case (v & 9'h1FE)
      O_LU:    return 0;
      O_MDU:   return 1;
      O_RDR:   return 2;
      O_MEMW:  return 3;
      default: return -1;
    endcase
  endfunction

  task automatic idle_inputs();
    rf_we_ex = 1'b0; rf_we_mem = 1'b0;
    rf_wd_sel_ex = 2'b00; rf_wd_sel_mem = 2'b00;
    rf_wa_ex = '0; rf_wa_mem = '0; rf_ra0_id = '0; rf_ra1_id = '0;
    npc_sel = 2'b00; mdu_start_ex = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic ex_load(input logic [RA_W-1:0] wa, input logic [RA_W-1:0] ra0,
                         input logic [RA_W-1:0] ra1);
    rf_we_ex = 1'b1; rf_wd_sel_ex = 2'b01; rf_wa_ex = wa;
    rf_ra0_id = ra0; rf_ra1_id = ra1;
  endtask

  // One clock cycle: inputs already applied just after the rising edge.
  task automatic step(input logic [8:0] ea, input logic [8:0] eb, input string tag);
    exp_t e;
    int   c;
    e.a = ea; e.b = eb; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      if (!rstn) begin
        for (int k = 0; k < 4; k++) begin ta[k] = 0; tbc[k] = 0; end
      end
      n_cmp++;
      if (out_a !== e.a) begin
        n_bad++; $display("FAIL %s out_a: got %b want %b", e.tag, out_a, e.a);
      end
      n_cmp++;
      if (out_b !== e.b) begin
        n_bad++; $display("FAIL %s out_b: got %b want %b", e.tag, out_b, e.b);
      end
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (cnt_a[k] !== 16'(ta[k])) begin
          n_bad++; $display("FAIL %s cnt_a[%0d]: got %0d want %0d", e.tag, k, cnt_a[k], ta[k]);
        end
        n_cmp++;
        if (cnt_b[k] !== 2'(tbc[k])) begin
          n_bad++; $display("FAIL %s cnt_b[%0d]: got %0d want %0d", e.tag, k, cnt_b[k], tbc[k]);
        end
      end
      if (rstn) begin
        c = cls(e.a);
        if (c >= 0 && ta[c] < 65535) ta[c]++;
        c = cls(e.b);
        if (c >= 0 && tbc[c] < 3) tbc[c]++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs(); rstn = 1'b0;
    step(O_NONE, O_NONE, "rst_idle");
    ex_load(5'd4, 5'd4, 5'd0);
    step(O_LU, O_LU, "rst_comb_hazard");
    idle_inputs(); rstn = 1'b1;
    step(O_NONE, O_NONE, "rst_release");
  endtask

  task automatic test_load_use();
    ex_load(5'd5, 5'd5, 5'd0);
    step(O_LU, O_LU, "lu_ex_ra0");
    idle_inputs();
    step(O_NONE, O_NONE, "lu_after");
    ex_load(5'd9, 5'd3, 5'd9);
    step(O_LU, O_LU, "lu_ex_ra1");
    ex_load(5'd5, 5'd5, 5'd0); rf_wd_sel_ex = 2'b00;
    step(O_NONE, O_NONE, "lu_not_load");
    ex_load(5'd5, 5'd5, 5'd0); rf_we_ex = 1'b0;
    step(O_NONE, O_NONE, "lu_no_we");
    ex_load(5'd5, 5'd6, 5'd7);
    step(O_NONE, O_NONE, "lu_no_match");
    idle_inputs();
  endtask

  task automatic test_zero_addr();
    ex_load(5'd0, 5'd0, 5'd0);
    step(O_NONE, O_NONE, "zero_ex");
    idle_inputs();
    rf_we_mem = 1'b1; rf_wd_sel_mem = 2'b01; rf_wa_mem = 5'd0;
    step(O_NONE, O_NONE, "zero_mem");
    idle_inputs();
  endtask

  task automatic test_mdu();
    mdu_start_ex = 1'b1;
    for (int i = 0; i < 4; i++) step(O_MDU, O_MDU, "mdu_stall");
    step(O_DONE, O_DONE, "mdu_done");
    mdu_start_ex = 1'b0;
    step(O_NONE, O_NONE, "mdu_idle");
  endtask

  task automatic test_mem_wait();
    mdu_start_ex = 1'b1;
    step(O_MDU, O_MDU, "mw_start");
    step(O_MDU, O_MDU, "mw_busy1");
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(O_MEMW, O_MEMW, "mw_wait");
    dmem_ready = 1'b1;
    step(O_MDU, O_MDU, "mw_busy2");
    step(O_MDU, O_MDU, "mw_busy3");
    step(O_DONE, O_DONE, "mw_done");
    mdu_start_ex = 1'b0;
    step(O_NONE, O_NONE, "mw_idle");
  endtask

  task automatic test_redirect();
    rf_we_mem = 1'b1; rf_wd_sel_mem = 2'b01; rf_wa_mem = 5'd7; rf_ra1_id = 5'd7;
    npc_sel = 2'b10;
    step(O_RDR, O_RDR, "rdr_over_lu_mem");
    npc_sel = 2'b00;
    step(O_NONE, O_LU, "lu_mem_only");
    idle_inputs(); npc_sel = 2'b01;
    step(O_RDR, O_RDR, "rdr_branch");
    npc_sel = 2'b11;
    step(O_NONE, O_NONE, "npc_11");
    idle_inputs();
  endtask

  task automatic test_priority();
    ex_load(5'd12, 5'd12, 5'd0); npc_sel = 2'b01;
    step(O_LU, O_LU, "lu_over_rdr");
    dmem_ready = 1'b0;
    step(O_MEMW, O_MEMW, "memw_over_lu");
    dmem_ready = 1'b1; npc_sel = 2'b00; mdu_start_ex = 1'b1;
    for (int i = 0; i < 4; i++) step(O_MDU, O_MDU, "mdu_over_lu");
    step(O_LU | O_DONE, O_LU | O_DONE, "done_with_lu");
    idle_inputs();
    step(O_NONE, O_NONE, "prio_idle");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      ex_load(RA_W'(i + 1), 5'd31, RA_W'(i + 1));
      step(O_LU, O_LU, "b2b_lu");
    end
    idle_inputs();
    step(O_NONE, O_NONE, "b2b_idle");
    n_cmp++;
    if (cnt_b[0] !== 2'd3) begin
      n_bad++; $display("FAIL sat_cnt_b: got %0d want 3", cnt_b[0]);
    end
  endtask

  task automatic test_reset_busy();
    mdu_start_ex = 1'b1;
    step(O_MDU, O_MDU, "rb_start");
    step(O_MDU, O_MDU, "rb_busy");
    mdu_start_ex = 1'b0; rstn = 1'b0;
    step(O_NONE, O_NONE, "rb_in_reset");
    rstn = 1'b1;
    step(O_NONE, O_NONE, "rb_released");
    mdu_start_ex = 1'b1;
    for (int i = 0; i < 4; i++) step(O_MDU, O_MDU, "rb_fresh");
    step(O_DONE, O_DONE, "rb_done");
    mdu_start_ex = 1'b0;
    step(O_NONE, O_NONE, "rb_idle");
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_zero_addr();
    test_mdu();
    test_mem_wait();
    test_redirect();
    test_priority();
    test_back_to_back();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
